// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding for the input debouncer
package debounce_pkg;
   typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} db_state_t;
endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - plain flop chain bringing an asynchronous input into clk
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk) begin
      if (reset) stages <= '0;
      else       stages <= {stages[SYNC_STAGES-2:0], d};
   end

   assign q = stages[SYNC_STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise, qualify and strobe a bouncy raw input
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic db_out,
   output logic rise,
   output logic fall,
   output logic busy
);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic            s;
   db_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic            db_nxt, rise_nxt, fall_nxt;

   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (raw_in),
      .q     (s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE_LO;
         cnt    <= '0;
         db_out <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         db_out <= db_nxt;
         rise   <= rise_nxt;
         fall   <= fall_nxt;
      end
   end

   // The first differing sample already counts as 1 of the STABLE_CYCLES samples.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = db_out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LO: if (s) begin
            state_nxt = CHK_HI;
            cnt_nxt   = CNT_W'(1);
         end
         CHK_HI: if (!s) begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
         end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_HI;
            cnt_nxt   = '0;
            db_nxt    = 1'b1;
            rise_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
         IDLE_HI: if (!s) begin
            state_nxt = CHK_LO;
            cnt_nxt   = CNT_W'(1);
         end
         CHK_LO: if (s) begin
            state_nxt = IDLE_HI;
            cnt_nxt   = '0;
         end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
            db_nxt    = 1'b0;
            fall_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
         default: begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy = (state == CHK_HI) || (state == CHK_LO);
   end
endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - self-checking bench for input_debouncer
module tb_input_debouncer;
   localparam int SYNC   = 2;
   localparam int STABLE = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic raw_in = 1'b0;
   logic db_out, rise, fall, busy;

   int tests_run = 0;
   int tests_failed = 0;

   logic rh[$];
   logic sq[$];
   logic m_db = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
   int   edge_n = 0;

   always #5 clk = ~clk;

   input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
      .clk    (clk),
      .reset  (reset),
      .raw_in (raw_in),
      .db_out (db_out),
      .rise   (rise),
      .fall   (fall),
      .busy   (busy)
   );

   // Reference: s is raw delayed SYNC edges since reset; level flips once the
   // last STABLE samples all disagree with it; busy while the newest sample disagrees.
   task automatic step(input logic r, input logic rst);
      logic s;
      logic flip;
      raw_in = r;
      reset  = rst;
      @(posedge clk);
      if (rst) begin
         rh.delete();
         sq.delete();
         m_db = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
         edge_n = 0;
      end else begin
         edge_n++;
         rh.push_back(r);
         s = (rh.size() > SYNC) ? rh[rh.size()-1-SYNC] : 1'b0;
         sq.push_back(s);
         flip = (sq.size() >= STABLE);
         for (int i = 1; i <= STABLE; i++)
            if (sq.size() >= i && sq[sq.size()-i] == m_db) flip = 1'b0;
         m_rise = flip && !m_db;
         m_fall = flip && m_db;
         if (flip) m_db = !m_db;
         m_busy = (sq[sq.size()-1] != m_db);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b1);
         tests_run++;
         if ({db_out, rise, fall, busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs cycle %0d: got %b expected 0000", k, {db_out, rise, fall, busy});
         end
      end
   endtask

   task automatic test_clean_rise();
      step(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0);
         tests_run++;
         if (db_out !== (k >= 6) || rise !== (k == 6) || busy !== (k >= 3 && k <= 5) || fall !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_rise edge %0d: got db=%b rise=%b busy=%b fall=%b expected db=%b rise=%b busy=%b fall=0",
                     k, db_out, rise, busy, fall, k >= 6, k == 6, k >= 3 && k <= 5);
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      for (int k = 0; k < 13; k++) begin
         step(k < 5 ? pat[k] : 1'b0, 1'b0);
         tests_run++;
         if (db_out !== 1'b0 || rise !== 1'b0 || busy !== m_busy) begin
            tests_failed++;
            $display("FAIL bounce step %0d: got db=%b rise=%b busy=%b expected db=0 rise=0 busy=%b",
                     k, db_out, rise, busy, m_busy);
         end
      end
   endtask

   task automatic test_clean_fall();
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
      tests_run++;
      if (db_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL fall_setup: got db=%b expected 1", db_out);
      end
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 1'b0);
         tests_run++;
         if (db_out !== (k < 6) || fall !== (k == 6) || busy !== (k >= 3 && k <= 5) || rise !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_fall edge %0d: got db=%b fall=%b busy=%b rise=%b expected db=%b fall=%b busy=%b rise=0",
                     k, db_out, fall, busy, rise, k < 6, k == 6, k >= 3 && k <= 5);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1);
      for (int k = 1; k <= 3; k++) step(1'b1, 1'b0);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_busy_before_reset: got %b expected 1", busy);
      end
      step(1'b1, 1'b1);
      tests_run++;
      if ({db_out, rise, fall, busy} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL mid_reset_abort: got %b expected 0000", {db_out, rise, fall, busy});
      end
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0);
         tests_run++;
         if (db_out !== (k >= 6) || rise !== (k == 6) || busy !== (k >= 3 && k <= 5)) begin
            tests_failed++;
            $display("FAIL mid_restart edge %0d: got db=%b rise=%b busy=%b expected db=%b rise=%b busy=%b",
                     k, db_out, rise, busy, k >= 6, k == 6, k >= 3 && k <= 5);
         end
      end
   endtask

   task automatic test_chained();
      logic pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic a_prev;
      int   y_count;
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      a_prev  = db_out;
      y_count = 0;
      for (int k = 0; k < 16; k++) begin
         step(k < 5 ? pat[k] : 1'b1, 1'b0);
         if (db_out && !a_prev) y_count++;
         a_prev = db_out;
      end
      tests_run++;
      if (y_count !== 1) begin
         tests_failed++;
         $display("FAIL chained_y_pulses: got %0d expected 1", y_count);
      end
   endtask

   task automatic test_random();
      logic lvl;
      int   run;
      int   n;
      step(1'b0, 1'b1);
      n = 0;
      while (n < 600) begin
         lvl = 1'($urandom_range(0, 1));
         run = $urandom_range(1, 7);
         for (int j = 0; j < run; j++) begin
            step(lvl, ($urandom_range(0, 79) == 0));
            n++;
            tests_run++;
            if (db_out !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy || (rise && fall)) begin
               tests_failed++;
               $display("FAIL random step %0d: got db=%b rise=%b fall=%b busy=%b expected db=%b rise=%b fall=%b busy=%b",
                        n, db_out, rise, fall, busy, m_db, m_rise, m_fall, m_busy);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_clean_rise();
      test_bounce();
      test_clean_fall();
      test_reset_mid();
      test_chained();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
